// File: rtl/mem_responder.sv
// mem_responder: bus responder with RAM, writable vectors and interval timer.
// Optional BUS_ERR output enabled by defining MEM_RESPONDER_BUS_ERR_EN.
module mem_responder #(
  parameter int          RAM_AW      = 11,
  parameter logic [15:0] IO_BASE     = 16'h4000,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [15:0] NMI_VEC     = 16'h8000,
  parameter logic [15:0] RESET_VEC   = 16'h8000,
  parameter logic [15:0] IRQ_VEC     = 16'h8000
) (
  input  logic       CLK,
  input  logic       RES_N,
  input  logic       VALID,
  input  logic [7:0] ABL,
  input  logic [7:0] ABH,
  input  logic       RW,
  input  logic [7:0] DB_IN,
  output logic [7:0] DB_OUT,
  output logic       RDY,
  output logic       IRQ_N
`ifdef MEM_RESPONDER_BUS_ERR_EN
  ,
  output logic       BUS_ERR
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [3:0]  WC      = 4'(WAIT_CYCLES);
  localparam logic [16:0] RAM_TOP = 17'(1) << RAM_AW;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wd_q;

  logic [15:0] a_addr;
  logic        a_rw;
  logic [7:0]  a_wd;
  logic        go_resp;
  logic        wr_en;
  logic        rd_en;

  logic        sel_vec;
  logic        sel_io;
  logic        sel_ram;
  logic [15:0] io_off;
  logic [2:0]  vidx;
  logic [7:0]  rdata;
  logic [7:0]  io_rd;

  logic [7:0]  ram [2**RAM_AW];
  logic [7:0]  vec [6];

  logic [7:0]  tlatch;
  logic [7:0]  tcount;
  logic        t_en;
  logic        t_irq_en;
  logic        expired;

  // In IDLE the live bus is the access (zero-wait case); later the captured copy.
  assign a_addr  = (state == ST_IDLE) ? {ABH, ABL} : addr_q;
  assign a_rw    = (state == ST_IDLE) ? RW : rw_q;
  assign a_wd    = (state == ST_IDLE) ? DB_IN : wd_q;

  assign go_resp = ((state == ST_IDLE) && VALID && (WC == 4'd0)) ||
                   ((state == ST_WAIT) && (cnt == 4'd1));
  assign wr_en   = go_resp && !a_rw;
  assign rd_en   = go_resp && a_rw;

  assign io_off  = a_addr - IO_BASE;
  assign vidx    = a_addr[2:0] - 3'd2;
  assign sel_vec = (a_addr >= 16'hFFFA);
  assign sel_io  = !sel_vec && (io_off < 16'd4);
  assign sel_ram = !sel_vec && !sel_io && ({1'b0, a_addr} < RAM_TOP);

  // Timer register read mux.
  always_comb begin
    io_rd = 8'h00;
    case (io_off[1:0])
      2'd0:    io_rd = tlatch;
      2'd1:    io_rd = tcount;
      2'd2:    io_rd = {6'd0, t_irq_en, t_en};
      default: io_rd = {7'd0, expired};
    endcase
  end

  // Address-decoded read data; unmapped reads return all ones.
  always_comb begin
    rdata = 8'hFF;
    unique case (1'b1)
      sel_vec: rdata = vec[vidx];
      sel_io:  rdata = io_rd;
      sel_ram: rdata = ram[a_addr[RAM_AW-1:0]];
      default: rdata = 8'hFF;
    endcase
  end

  // RAM array; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en && sel_ram)
      ram[a_addr[RAM_AW-1:0]] <= a_wd;
  end

  // Vector bytes, reloaded from parameters on reset.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      vec[0] <= NMI_VEC[7:0];
      vec[1] <= NMI_VEC[15:8];
      vec[2] <= RESET_VEC[7:0];
      vec[3] <= RESET_VEC[15:8];
      vec[4] <= IRQ_VEC[7:0];
      vec[5] <= IRQ_VEC[15:8];
    end else if (wr_en && sel_vec) begin
      vec[vidx] <= a_wd;
    end
  end

  // Interval timer: count, reload, sticky expired flag, registered IRQ_N.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      tlatch   <= 8'h00;
      tcount   <= 8'h00;
      t_en     <= 1'b0;
      t_irq_en <= 1'b0;
      expired  <= 1'b0;
      IRQ_N    <= 1'b1;
    end else begin
      if (t_en) begin
        if (tcount == 8'h00)
          tcount <= tlatch;
        else
          tcount <= tcount - 8'd1;
      end
      if (wr_en && sel_io && io_off[1:0] == 2'd0) begin
        tlatch <= a_wd;
        if (!t_en)
          tcount <= a_wd;
      end
      if (wr_en && sel_io && io_off[1:0] == 2'd2) begin
        t_en     <= a_wd[0];
        t_irq_en <= a_wd[1];
      end
      if (t_en && tcount == 8'h00)
        expired <= 1'b1;
      else if (wr_en && sel_io && io_off[1:0] == 2'd3 && a_wd[0])
        expired <= 1'b0;
      IRQ_N <= ~(expired & t_irq_en);
    end
  end

`ifdef MEM_RESPONDER_BUS_ERR_EN
  logic err_q;
  logic err_now;

  assign err_now = (!sel_vec && !sel_io && !sel_ram) ||
                   (sel_io && io_off[1:0] == 2'd1 && !a_rw);

  // Error flag latched with the access and presented alongside RDY.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      err_q   <= 1'b0;
      BUS_ERR <= 1'b0;
    end else begin
      if (go_resp)
        err_q <= err_now;
      BUS_ERR <= (state == ST_RESP) && err_q;
    end
  end
`endif

  // Access FSM: capture, wait states, commit, one-cycle RDY strobe.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      state  <= ST_IDLE;
      cnt    <= 4'd0;
      addr_q <= 16'h0000;
      rw_q   <= 1'b1;
      wd_q   <= 8'h00;
      DB_OUT <= 8'h00;
      RDY    <= 1'b0;
    end else begin
      RDY <= (state == ST_RESP);
      if (rd_en)
        DB_OUT <= rdata;
      case (state)
        ST_IDLE: begin
          if (VALID) begin
            addr_q <= {ABH, ABL};
            rw_q   <= RW;
            wd_q   <= DB_IN;
            cnt    <= WC;
            state  <= (WC == 4'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed + randomized checks of mem_responder.
// Two instances share the bus: WAIT_CYCLES=1 (main) and WAIT_CYCLES=0.
module tb_mem_responder;

  localparam logic [15:0] IOB = 16'h4000;

  logic       clk   = 1'b0;
  logic       res_n = 1'b0;
  logic       valid = 1'b0;
  logic       rw    = 1'b1;
  logic [7:0] abl   = 8'h00;
  logic [7:0] abh   = 8'h00;
  logic [7:0] db_in = 8'h00;
  logic [7:0] db_out, db_out0;
  logic       rdy, rdy0, irq_n, irq_n0;
  logic       berr, berr0;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0]  ram_m [2048];
  logic [7:0]  vec_m [6];
  logic [7:0]  last_rd;
  logic [15:0] pool [8];
  int tE, tL, tlo;
  bit ton;

  mem_responder #(.WAIT_CYCLES(1)) u_dut (
    .CLK(clk), .RES_N(res_n), .VALID(valid), .ABL(abl), .ABH(abh),
    .RW(rw), .DB_IN(db_in), .DB_OUT(db_out), .RDY(rdy), .IRQ_N(irq_n)
`ifdef MEM_RESPONDER_BUS_ERR_EN
    , .BUS_ERR(berr)
`endif
  );

  mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .CLK(clk), .RES_N(res_n), .VALID(valid), .ABL(abl), .ABH(abh),
    .RW(rw), .DB_IN(db_in), .DB_OUT(db_out0), .RDY(rdy0), .IRQ_N(irq_n0)
`ifdef MEM_RESPONDER_BUS_ERR_EN
    , .BUS_ERR(berr0)
`endif
  );

`ifndef MEM_RESPONDER_BUS_ERR_EN
  assign berr  = 1'b0;
  assign berr0 = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_unmapped(input logic [15:0] a);
    if (a >= 16'hFFFA) return 1'b0;
    if (a >= IOB && a < IOB + 16'd4) return 1'b0;
    return a >= 16'h0800;
  endfunction

  function automatic void reset_model();
    vec_m[0] = 8'h00; vec_m[1] = 8'h80;
    vec_m[2] = 8'h00; vec_m[3] = 8'h80;
    vec_m[4] = 8'h00; vec_m[5] = 8'h80;
    last_rd = 8'h00;
    ton = 1'b0;
    tlo = 0;
  endfunction

  // Expired flag after edge m: set edges are tE + n*(tL+1), n>=1;
  // a clear at edge tlo loses to a set on that same edge.
  function automatic bit flag_after(input int m);
    int base, k, s;
    if (!ton) return 1'b0;
    base = (tlo > tE + 1) ? tlo : tE + 1;
    k = (base - tE + tL) / (tL + 1);
    s = tE + k * (tL + 1);
    return s <= m;
  endfunction

  // Count visible just before edge r, enabled at edge tE from tL.
  function automatic int cnt_before(input int r);
    int k;
    k = r - 1 - tE;
    return (tL - (k % (tL + 1)) + tL + 1) % (tL + 1);
  endfunction

  task automatic access(input logic [15:0] a, input logic r,
                        input logic [7:0] d,
                        output logic [7:0] rd, output int lat,
                        output logic be, output logic [7:0] rd0,
                        output int lat0, output int cap);
    @(negedge clk);
    valid = 1'b1; {abh, abl} = a; rw = r; db_in = d;
    @(posedge clk); #1;
    valid = 1'b0;
    cap = cyc;
    lat = -1; lat0 = -1; be = 1'b0; rd = 8'h00; rd0 = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy0 && lat0 < 0) begin
        lat0 = k;
        rd0 = db_out0;
      end
      if (rdy) begin
        lat = k;
        rd = db_out;
        be = berr;
        break;
      end
    end
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] a,
                        input logic [7:0] exp, input bit c0,
                        output int cap);
    logic [7:0] rd, rd0;
    int lat, lat0;
    logic be;
    access(a, 1'b1, 8'h00, rd, lat, be, rd0, lat0, cap);
    chk({tag, ".data"}, 32'(rd), 32'(exp));
    chk({tag, ".lat"}, 32'(lat), 32'd2);
    if (c0) begin
      chk({tag, ".data0"}, 32'(rd0), 32'(exp));
      chk({tag, ".lat0"}, 32'(lat0), 32'd1);
    end
`ifdef MEM_RESPONDER_BUS_ERR_EN
    chk({tag, ".berr"}, 32'(be), 32'(is_unmapped(a)));
`endif
    last_rd = exp;
  endtask

  task automatic wr_chk(input string tag, input logic [15:0] a,
                        input logic [7:0] d, output int cap);
    logic [7:0] rd, rd0;
    int lat, lat0;
    logic be;
    access(a, 1'b0, d, rd, lat, be, rd0, lat0, cap);
    chk({tag, ".hold"}, 32'(rd), 32'(last_rd));
    chk({tag, ".lat"}, 32'(lat), 32'd2);
`ifdef MEM_RESPONDER_BUS_ERR_EN
    chk({tag, ".berr"}, 32'(be),
        32'(is_unmapped(a) || a == IOB + 16'd1));
`endif
    if (a < 16'h0800) ram_m[a[10:0]] = d;
    if (a >= 16'hFFFA) vec_m[a[2:0] - 3'd2] = d;
  endtask

  task automatic irq_watch(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      chk(tag, 32'(irq_n), 32'(!flag_after(cyc - 1)));
    end
  endtask

  task automatic align(input int ph);
    while (((cyc + 2 - tE) % (tL + 1)) != ph) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int cap, kind, idx;
    logic [15:0] a;
    logic [7:0] d;

    reset_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdy", 32'(rdy), 32'd0);
    chk("rst.db", 32'(db_out), 32'h00);
    chk("rst.irq", 32'(irq_n), 32'd1);
    chk("rst.irq0", 32'(irq_n0), 32'd1);
    @(negedge clk) res_n = 1'b1;

    rd_chk("vec_fffc", 16'hFFFC, 8'h00, 1'b1, cap);
    rd_chk("vec_fffd", 16'hFFFD, 8'h80, 1'b1, cap);
    wr_chk("w0123", 16'h0123, 8'hA5, cap);
    rd_chk("r0123", 16'h0123, 8'hA5, 1'b1, cap);
    rd_chk("unmap2000", 16'h2000, 8'hFF, 1'b1, cap);

    pool[0] = 16'h0000; pool[1] = 16'h07FF;
    pool[2] = 16'h0123; pool[3] = 16'h0010;
    for (int i = 4; i < 8; i++) pool[i] = 16'($urandom_range(0, 2047));
    for (int i = 0; i < 8; i++)
      wr_chk("pool", pool[i], 8'($urandom_range(0, 255)), cap);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      d = 8'($urandom_range(0, 255));
      idx = $urandom_range(0, 7);
      case (kind)
        0: wr_chk("rnd.wram", pool[idx], d, cap);
        1: rd_chk("rnd.rram", pool[idx], ram_m[pool[idx][10:0]], 1'b1, cap);
        2: begin
          a = 16'hFFFA + 16'($urandom_range(0, 5));
          wr_chk("rnd.wvec", a, d, cap);
        end
        3: begin
          a = 16'hFFFA + 16'($urandom_range(0, 5));
          rd_chk("rnd.rvec", a, vec_m[a[2:0] - 3'd2], 1'b1, cap);
        end
        default: begin
          a = 16'h0800 + 16'($urandom_range(0, 16'h37FF));
          if (d[0]) wr_chk("rnd.wun", a, d, cap);
          else rd_chk("rnd.run", a, 8'hFF, 1'b1, cap);
        end
      endcase
    end

    tL = 3;
    wr_chk("tlatch", IOB, 8'(tL), cap);
    wr_chk("tcount_wr", IOB + 16'd1, 8'h09, cap);
    wr_chk("tctrl", IOB + 16'd2, 8'h03, cap);
    tE = cap + 1;
    ton = 1'b1;
    irq_watch("irq.first", 10);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk); #1;
      rd_chk("tcount", IOB + 16'd1, 8'(cnt_before(cyc + 2)), 1'b0, cap);
    end
    rd_chk("tctrl_rd", IOB + 16'd2, 8'h03, 1'b0, cap);
    rd_chk("tstat_rd", IOB + 16'd3, 8'(flag_after(cyc + 1)), 1'b0, cap);

    align(2);
    wr_chk("tstat_clr", IOB + 16'd3, 8'h01, cap);
    tlo = cap + 1;
    irq_watch("irq.clr", 6);

    align(0);
    wr_chk("tstat_race", IOB + 16'd3, 8'h01, cap);
    tlo = cap + 1;
    chk("race.flag", 32'(flag_after(tlo)), 32'd1);
    irq_watch("irq.race", 3);
    rd_chk("tstat_race_rd", IOB + 16'd3, 8'(flag_after(cyc + 1)), 1'b0, cap);

    @(negedge clk);
    valid = 1'b1; {abh, abl} = 16'h0010; rw = 1'b0; db_in = ~ram_m[16];
    @(posedge clk); #1;
    valid = 1'b0;
    #2 res_n = 1'b0;
    #1;
    chk("mid.rdy", 32'(rdy), 32'd0);
    chk("mid.db", 32'(db_out), 32'h00);
    chk("mid.irq", 32'(irq_n), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("mid.rdy_hold", 32'(rdy), 32'd0);
    end
    @(negedge clk);
    res_n = 1'b1;
    rw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post.rdy", 32'(rdy), 32'd0);
    end
    reset_model();
    rd_chk("post.r0010", 16'h0010, ram_m[16], 1'b0, cap);
    for (int i = 0; i < 6; i++)
      rd_chk("post.vec", 16'hFFFA + 16'(i), vec_m[i], 1'b0, cap);
    rd_chk("post.tstat", IOB + 16'd3, 8'h00, 1'b0, cap);
    rd_chk("post.tctrl", IOB + 16'd2, 8'h00, 1'b0, cap);
    rd_chk("post.tlatch", IOB, 8'h00, 1'b0, cap);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
